stoch_decode: RTL and testbench

//  Decodes a unipolar stochastic bitstream back to binary by counting ones over a

---
 rtl/stoch_decode.sv | 132 +++++++++++++
 tb/tb_stoch_decode.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/stoch_decode.sv
// rtl/stoch_decode.sv - stochastic bitstream to binary decoder with one-entry output slot
//
// Purpose:
//   Counts the ones in each window of 2^WINDOW_BITS valid stream samples.
//   Each completed window's count is handed to binary logic through a
//   one-entry valid/ready slot. A window that completes while the slot is
//   still held is dropped, and the sticky overrun flag is set.
//
// Ports:
//   CLK          in   1                clock, all state updates on posedge
//   nRST         in   1                synchronous active-low reset
//   en           in   1                x is a valid stream sample this cycle
//   x            in   1                stochastic stream bit
//   clear        in   1                synchronous window restart (drops partial count)
//   y_data       out  WINDOW_BITS+1    ones count of last completed window
//   y_valid      out  1                y_data holds an unconsumed result
//   y_ready      in   1                consumer accepts y_data when y_valid=1
//   overrun      out  1                sticky: a completed window was dropped
//   overrun_clr  in   1                clears overrun (a same-cycle drop wins)

module stoch_decode #(
  parameter int WINDOW_BITS = 8
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   en,
  input  logic                   x,
  input  logic                   clear,
  output logic [WINDOW_BITS:0]   y_data,
  output logic                   y_valid,
  input  logic                   y_ready,
  output logic                   overrun,
  input  logic                   overrun_clr
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  logic [WINDOW_BITS-1:0] r_sample_cnt;
  logic [WINDOW_BITS:0]   r_acc;
  logic [WINDOW_BITS:0]   r_y_data;
  logic                   r_overrun;
  state_t                 r_state;

  logic                   w_accept;
  logic                   w_win_end;
  logic [WINDOW_BITS:0]   w_result;
  state_t                 w_state_nxt;
  logic                   w_load;
  logic                   w_drop;

  // clear outranks en, so a sample arriving with clear is never counted,
  // even when it would have been the last sample of the window.
  assign w_accept  = en & ~clear;
  assign w_win_end = w_accept & (r_sample_cnt == {WINDOW_BITS{1'b1}});
  // Full-width sum: an all-ones window yields exactly 2^WINDOW_BITS.
  assign w_result  = r_acc + {{WINDOW_BITS{1'b0}}, x};

  // Sample counter and ones accumulator. Both restart in the window-end cycle
  // itself, so the next sample already belongs to the new window.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_sample_cnt <= '0;
      r_acc        <= '0;
    end else if (clear) begin
      r_sample_cnt <= '0;
      r_acc        <= '0;
    end else if (w_win_end) begin
      r_sample_cnt <= '0;
      r_acc        <= '0;
    end else if (en) begin
      r_sample_cnt <= r_sample_cnt + 1'b1;
      r_acc        <= w_result;
    end
  end

  // Output slot next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_win_end) begin
          w_load      = 1'b1;
          w_state_nxt = S_FULL;
        end
      end
      S_FULL: begin
        if (w_win_end) begin
          // The consumer taking the old value in the same cycle frees the
          // slot for the new one, so there is no bubble between results.
          if (y_ready) begin
            w_load = 1'b1;
          end else begin
            w_drop = 1'b1;
          end
        end else if (y_ready) begin
          w_state_nxt = S_EMPTY;
        end
      end
      default: begin
        w_state_nxt = S_EMPTY;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state   <= S_EMPTY;
      r_y_data  <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_y_data <= w_result;
      end
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (overrun_clr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign y_data  = r_y_data;
  assign y_valid = (r_state == S_FULL);
  assign overrun = r_overrun;

endmodule

// File: tb/tb_stoch_decode.sv
// tb/tb_stoch_decode.sv - self-checking bench for stoch_decode (WINDOW_BITS=4)

module tb_stoch_decode;

  localparam int WB  = 4;
  localparam int WIN = 1 << WB;

  logic          CLK = 1'b0;
  logic          nRST;
  logic          en;
  logic          x;
  logic          clear;
  logic [WB:0]   y_data;
  logic          y_valid;
  logic          y_ready;
  logic          overrun;
  logic          overrun_clr;

  int checks = 0;
  int errors = 0;

  // Behavioural model: how many samples and ones the current window holds,
  // plus the delivered result slot and the sticky drop flag.
  int m_cnt   = 0;
  int m_ones  = 0;
  int m_valid = 0;
  int m_data  = 0;
  int m_ovr   = 0;

  stoch_decode #(.WINDOW_BITS(WB)) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .en          (en),
    .x           (x),
    .clear       (clear),
    .y_data      (y_data),
    .y_valid     (y_valid),
    .y_ready     (y_ready),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Compare DUT against the model on every falling edge.
  always @(negedge CLK) begin
    chk("y_data",  int'(y_data),  m_data);
    chk("y_valid", int'(y_valid), m_valid);
    chk("overrun", int'(overrun), m_ovr);
  end

  // Apply one cycle of inputs, advance the model at the rising edge, and
  // return at the following falling edge.
  task automatic cyc(input logic rn, input logic e, input logic xv,
                     input logic cl, input logic rdy, input logic oc);
    int  res;
    bit  done;
    bit  drop;
    nRST = rn; en = e; x = xv; clear = cl; y_ready = rdy; overrun_clr = oc;
    @(posedge CLK);
    if (!rn) begin
      m_cnt = 0; m_ones = 0; m_valid = 0; m_data = 0; m_ovr = 0;
    end else begin
      done = 0;
      drop = 0;
      res  = 0;
      if (cl) begin
        m_cnt = 0; m_ones = 0;
      end else if (e) begin
        m_ones = m_ones + int'(xv);
        m_cnt  = m_cnt + 1;
        if (m_cnt == WIN) begin
          done = 1; res = m_ones; m_cnt = 0; m_ones = 0;
        end
      end
      if (done) begin
        if (m_valid == 0 || rdy) begin
          m_data = res; m_valid = 1;
        end else begin
          drop = 1;
        end
      end else if (m_valid == 1 && rdy) begin
        m_valid = 0;
      end
      if (drop) m_ovr = 1;
      else if (oc) m_ovr = 0;
    end
    @(negedge CLK);
  endtask

  initial begin
    // reset
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("reset_y_valid", int'(y_valid), 0);
    chk("reset_y_data",  int'(y_data),  0);
    chk("reset_overrun", int'(overrun), 0);

    // 1: all-ones window gives the full-width count
    for (int i = 0; i < WIN; i++) begin
      if (i == WIN - 1) chk("s1_no_early_valid", int'(y_valid), 0);
      cyc(1, 1, 1, 0, 0, 0);
    end
    chk("s1_valid", int'(y_valid), 1);
    chk("s1_data",  int'(y_data), 16);
    chk("s1_ovr",   int'(overrun), 0);
    cyc(1, 0, 0, 0, 1, 0);
    chk("s1_consumed", int'(y_valid), 0);

    // 2: alternating stream gives half
    for (int i = 0; i < WIN; i++) cyc(1, 1, (i % 2 == 0), 0, 0, 0);
    chk("s2_data", int'(y_data), 8);
    cyc(1, 0, 0, 0, 1, 0);
    chk("s2_consumed", int'(y_valid), 0);

    // 3: second window dropped while slot held
    for (int i = 0; i < 40; i++) cyc(1, 1, (i < 16), 0, 0, 0);
    chk("s3_data_held", int'(y_data), 16);
    chk("s3_overrun",   int'(overrun), 1);
    cyc(1, 0, 0, 0, 0, 1);
    chk("s3_ovr_clr",   int'(overrun), 0);
    chk("s3_data_still", int'(y_data), 16);
    cyc(1, 0, 0, 1, 1, 0);

    // 4: consume in the exact cycle of the next window end
    for (int i = 0; i < WIN; i++) cyc(1, 1, 1, 0, 0, 0);
    for (int i = 0; i < WIN; i++) cyc(1, 1, 0, 0, (i == WIN - 1), 0);
    chk("s4_valid_stays", int'(y_valid), 1);
    chk("s4_data_new",    int'(y_data), 0);
    chk("s4_no_ovr",      int'(overrun), 0);
    cyc(1, 0, 0, 0, 1, 0);

    // 5: gapped enable, then clear mid-window
    for (int i = 0; i < 2 * WIN; i++) cyc(1, (i % 2 == 0), 1, 0, 0, 0);
    chk("s5_gapped_data", int'(y_data), 16);
    cyc(1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 10; i++) cyc(1, 1, 1, 0, 0, 0);
    cyc(1, 1, 1, 1, 0, 0);
    for (int i = 0; i < WIN; i++) begin
      if (i == WIN - 1) chk("s5_no_early_result", int'(y_valid), 0);
      cyc(1, 1, (i < 4), 0, 0, 0);
    end
    chk("s5_post_clear", int'(y_data), 4);
    cyc(1, 0, 0, 0, 1, 0);

    // 6: reset mid-window with a held result
    for (int i = 0; i < WIN + 7; i++) cyc(1, 1, 1, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0);
    chk("s6_rst_valid", int'(y_valid), 0);
    chk("s6_rst_data",  int'(y_data), 0);
    for (int i = 0; i < WIN; i++) cyc(1, 1, 1, 0, 0, 0);
    chk("s6_data", int'(y_data), 16);

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      cyc(($urandom_range(0, 499) != 0),
          ($urandom_range(0, 3) != 0),
          1'($urandom),
          ($urandom_range(0, 39) == 0),
          1'($urandom),
          ($urandom_range(0, 19) == 0));
    end

    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
